// File: rtl/riscv_defines.sv
// Shared CSR-operation encodings and performance-monitor address map.
package riscv_defines;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [11:0] HPM_CNT_LO_BASE = 12'hB03;
    localparam logic [11:0] HPM_CNT_HI_BASE = 12'hB83;
    localparam logic [11:0] HPM_EVT_BASE    = 12'h323;
    localparam logic [11:0] HPM_INHIBIT     = 12'h320;
    localparam logic [11:0] HPM_MODE        = 12'h7A1;
    localparam logic [11:0] HPM_OVF         = 12'h7A2;
    localparam logic [11:0] HPM_OVF_EN      = 12'h7A3;

    localparam int unsigned HPM_MODE_EN_BIT  = 0;
    localparam int unsigned HPM_MODE_SAT_BIT = 1;

    // New register value for a CSR operation applied to the current value q.
    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] q,
                                              input logic [31:0] wdata);
        logic [31:0] res;
        res = q;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = q | wdata;
            CSR_OP_CLEAR: res = q & ~wdata;
            default:      res = q;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_hpm_counter.sv
// One performance counter: registered increment request, lo/hi write ports,
// wrap or saturate at all-ones, and a single-cycle overflow pulse.
module riscv_hpm_counter
    import riscv_defines::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             sat_i,
    input  logic             lo_we_i,
    input  logic             hi_we_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_set_o
);

    localparam int unsigned HI_W = CNT_W - 32;

    logic             inc_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;

    assign at_max    = &cnt_q;
    // A software write to either word swallows the increment, so no overflow either.
    assign ovf_set_o = inc_q & at_max & ~(lo_we_i | hi_we_i);
    assign cnt_o     = cnt_q;

    // Next counter value: CSR write first, then increment with wrap/saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (lo_we_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (hi_we_i) begin
            cnt_d[CNT_W-1:32] = wdata_i[HI_W-1:0];
        end else if (inc_q) begin
            if (!at_max) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!sat_i) begin
                cnt_d = '0;
            end
        end
    end

    // Counter and increment-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            inc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inc_q <= inc_i;
        end
    end

endmodule

// File: rtl/riscv_hpm_counters.sv
// Performance-monitor unit: CSR decode/read mux, event selection, control and
// overflow status registers, and N_CNT counter instances.
module riscv_hpm_counters
    import riscv_defines::*;
#(
    parameter int unsigned N_CNT    = 4,
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned N_EVENTS = 16,
    parameter int unsigned EVT_W    = $clog2(N_EVENTS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [1:0]          csr_op_i,
    input  logic [31:0]         csr_wdata_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] events_i,
    output logic                ovf_irq_o
);

    csr_op_e          op;
    logic [N_CNT-1:0] lo_hit, hi_hit, evt_hit;
    logic             inhibit_hit, mode_hit, ovf_hit, ovf_en_hit, addr_hit, we;
    logic [31:0]      rdata, wval;

    logic [EVT_W-1:0] evt_sel_q [N_CNT];
    logic [EVT_W-1:0] evt_sel_d [N_CNT];
    logic [N_CNT-1:0] inhibit_q, inhibit_d, ovf_q, ovf_d, ovf_en_q, ovf_en_d;
    logic [N_CNT-1:0] ovf_set, inc, ev_sel;
    logic [1:0]       mode_q, mode_d;
    logic             irq_q;
    logic [CNT_W-1:0] cnt [N_CNT];

    assign op          = csr_op_e'(csr_op_i);
    assign csr_hit_o   = csr_access_i & addr_hit;
    assign csr_rdata_o = rdata;
    assign ovf_irq_o   = irq_q;
    assign we          = csr_access_i & addr_hit & (op != CSR_OP_NONE);
    assign wval        = csr_apply(op, rdata, csr_wdata_i);

    // Address decode.
    always_comb begin
        lo_hit  = '0;
        hi_hit  = '0;
        evt_hit = '0;
        for (int i = 0; i < int'(N_CNT); i++) begin
            lo_hit[i]  = (csr_addr_i == HPM_CNT_LO_BASE + 12'(i));
            hi_hit[i]  = (csr_addr_i == HPM_CNT_HI_BASE + 12'(i));
            evt_hit[i] = (csr_addr_i == HPM_EVT_BASE + 12'(i));
        end
        inhibit_hit = (csr_addr_i == HPM_INHIBIT);
        mode_hit    = (csr_addr_i == HPM_MODE);
        ovf_hit     = (csr_addr_i == HPM_OVF);
        ovf_en_hit  = (csr_addr_i == HPM_OVF_EN);
        addr_hit    = (|lo_hit) | (|hi_hit) | (|evt_hit) | inhibit_hit | mode_hit |
                      ovf_hit | ovf_en_hit;
    end

    // Read mux; also the q operand for SET/CLEAR.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(N_CNT); i++) begin
            if (lo_hit[i])  rdata = cnt[i][31:0];
            if (hi_hit[i])  rdata = 32'(cnt[i][CNT_W-1:32]);
            if (evt_hit[i]) rdata = 32'(evt_sel_q[i]);
        end
        if (inhibit_hit) rdata = 32'(inhibit_q);
        if (mode_hit)    rdata = 32'(mode_q);
        if (ovf_hit)     rdata = 32'(ovf_q);
        if (ovf_en_hit)  rdata = 32'(ovf_en_q);
    end

    // Event-select mux; select values 0 and above N_EVENTS never match.
    always_comb begin
        ev_sel = '0;
        inc    = '0;
        for (int i = 0; i < int'(N_CNT); i++) begin
            for (int e = 0; e < int'(N_EVENTS); e++) begin
                if (evt_sel_q[i] == EVT_W'(e + 1)) ev_sel[i] = events_i[e];
            end
            inc[i] = ev_sel[i] & mode_q[HPM_MODE_EN_BIT] & ~inhibit_q[i];
        end
    end

    // Control-register next state; an overflow set beats a same-cycle clear.
    always_comb begin
        evt_sel_d = evt_sel_q;
        inhibit_d = inhibit_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        ovf_en_d  = ovf_en_q;
        if (we) begin
            for (int i = 0; i < int'(N_CNT); i++) begin
                if (evt_hit[i]) evt_sel_d[i] = wval[EVT_W-1:0];
            end
            if (inhibit_hit) inhibit_d = wval[N_CNT-1:0];
            if (mode_hit)    mode_d    = wval[1:0];
            if (ovf_hit)     ovf_d     = wval[N_CNT-1:0];
            if (ovf_en_hit)  ovf_en_d  = wval[N_CNT-1:0];
        end
        ovf_d = ovf_d | ovf_set;
    end

    // Control, status and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CNT); i++) evt_sel_q[i] <= '0;
            inhibit_q <= '0;
            mode_q    <= 2'b01;
            ovf_q     <= '0;
            ovf_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            evt_sel_q <= evt_sel_d;
            inhibit_q <= inhibit_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            ovf_en_q  <= ovf_en_d;
            irq_q     <= |(ovf_q & ovf_en_q);
        end
    end

    for (genvar g = 0; g < int'(N_CNT); g++) begin : g_cnt
        riscv_hpm_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc_i    (inc[g]),
            .sat_i    (mode_q[HPM_MODE_SAT_BIT]),
            .lo_we_i  (we & lo_hit[g]),
            .hi_we_i  (we & hi_hit[g]),
            .wdata_i  (wval),
            .cnt_o    (cnt[g]),
            .ovf_set_o(ovf_set[g])
        );
    end

endmodule

// File: tb/tb_riscv_hpm_counters.sv
// Self-checking bench for riscv_hpm_counters: directed scenarios plus randomized
// event streams checked against per-counter event tallies.
module tb_riscv_hpm_counters;
    import riscv_defines::*;

    localparam int unsigned N_CNT    = 4;
    localparam int unsigned CNT_W    = 64;
    localparam int unsigned N_EVENTS = 16;
    localparam int unsigned EVT_W    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                csr_access = 1'b0;
    logic [11:0]         csr_addr = '0;
    logic [1:0]          csr_op = CSR_OP_NONE;
    logic [31:0]         csr_wdata = '0;
    logic [31:0]         csr_rdata;
    logic                csr_hit;
    logic [N_EVENTS-1:0] events = '0;
    logic                ovf_irq;
    logic                last_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_hpm_counters #(
        .N_CNT   (N_CNT),
        .CNT_W   (CNT_W),
        .N_EVENTS(N_EVENTS),
        .EVT_W   (EVT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_access_i(csr_access),
        .csr_addr_i  (csr_addr),
        .csr_op_i    (csr_op),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .csr_hit_o   (csr_hit),
        .events_i    (events),
        .ovf_irq_o   (ovf_irq)
    );

    // All tasks start and end just after a rising edge; each CSR access uses one cycle.
    task automatic csr_write(input logic [11:0] addr, input logic [1:0] op,
                             input logic [31:0] data);
        csr_access = 1'b1; csr_addr = addr; csr_op = op; csr_wdata = data;
        @(posedge clk); #1;
        csr_access = 1'b0; csr_op = CSR_OP_NONE;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic hit);
        csr_access = 1'b1; csr_addr = addr; csr_op = CSR_OP_NONE;
        @(negedge clk);
        data = csr_rdata; hit = csr_hit; last_irq = ovf_irq;
        @(posedge clk); #1;
        csr_access = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic [N_EVENTS-1:0] ev);
        events = ev;
        @(posedge clk); #1;
        events = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h;
        for (int i = 0; i < int'(N_CNT); i++) begin
            csr_read(HPM_CNT_LO_BASE + 12'(i), d, h);
            n_tests++; if (d !== 32'h0 || h !== 1'b1) begin n_fail++;
                $display("FAIL reset_lo%0d: got %h hit %b, want 0 hit 1", i, d, h); end
            csr_read(HPM_CNT_HI_BASE + 12'(i), d, h);
            n_tests++; if (d !== 32'h0 || h !== 1'b1) begin n_fail++;
                $display("FAIL reset_hi%0d: got %h hit %b, want 0 hit 1", i, d, h); end
            csr_read(HPM_EVT_BASE + 12'(i), d, h);
            n_tests++; if (d !== 32'h0 || h !== 1'b1) begin n_fail++;
                $display("FAIL reset_sel%0d: got %h hit %b, want 0 hit 1", i, d, h); end
        end
        csr_read(HPM_INHIBIT, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL reset_inhibit: got %h, want 0", d); end
        csr_read(HPM_OVF, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL reset_ovf: got %h, want 0", d); end
        csr_read(HPM_OVF_EN, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL reset_ovf_en: got %h, want 0", d); end
        csr_read(HPM_MODE, d, h);
        n_tests++; if (d !== 32'h1 || h !== 1'b1) begin n_fail++;
            $display("FAIL reset_mode: got %h hit %b, want 1 hit 1", d, h); end
        n_tests++; if (last_irq !== 1'b0) begin n_fail++;
            $display("FAIL reset_irq: got %b, want 0", last_irq); end
        csr_read(12'h7A0, d, h);
        n_tests++; if (d !== 32'h0 || h !== 1'b0) begin n_fail++;
            $display("FAIL unmapped_7a0: got %h hit %b, want 0 hit 0", d, h); end
        csr_read(HPM_CNT_LO_BASE + 12'(N_CNT), d, h);
        n_tests++; if (d !== 32'h0 || h !== 1'b0) begin n_fail++;
            $display("FAIL unmapped_past_last: got %h hit %b, want 0 hit 0", d, h); end
        // Mapped address without an access strobe must not hit.
        csr_addr = HPM_MODE; csr_access = 1'b0;
        @(negedge clk);
        n_tests++; if (csr_hit !== 1'b0) begin n_fail++;
            $display("FAIL hit_without_access: got %b, want 0", csr_hit); end
        @(posedge clk); #1;
    endtask

    task automatic test_count();
        logic [31:0] d; logic h;
        csr_write(HPM_EVT_BASE, CSR_OP_WRITE, 32'd3);
        for (int k = 0; k < 5; k++) begin
            pulse(16'h0004);
            if (k != 4) idle(1);
        end
        csr_read(HPM_CNT_LO_BASE, d, h);   // one cycle after the last pulse
        n_tests++; if (d !== 32'd4) begin n_fail++;
            $display("FAIL count_latency_t1: got %h, want 4", d); end
        csr_read(HPM_CNT_LO_BASE, d, h);   // two cycles after the last pulse
        n_tests++; if (d !== 32'd5) begin n_fail++;
            $display("FAIL count_five: got %h, want 5", d); end
        csr_read(HPM_CNT_LO_BASE + 12'd1, d, h);
        n_tests++; if (d !== 32'd0) begin n_fail++;
            $display("FAIL count_unselected: got %h, want 0", d); end
    endtask

    task automatic test_carry();
        logic [31:0] d; logic h;
        csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'hFFFF_FFFF);
        csr_write(HPM_CNT_HI_BASE, CSR_OP_WRITE, 32'h0);
        pulse(16'h0004);
        idle(1);
        csr_read(HPM_CNT_LO_BASE, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL carry_lo: got %h, want 0", d); end
        csr_read(HPM_CNT_HI_BASE, d, h);
        n_tests++; if (d !== 32'h1) begin n_fail++;
            $display("FAIL carry_hi: got %h, want 1", d); end
        csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'h1234);
        csr_read(HPM_CNT_HI_BASE, d, h);
        n_tests++; if (d !== 32'h1) begin n_fail++;
            $display("FAIL lo_write_keeps_hi: got %h, want 1", d); end
        csr_write(HPM_CNT_HI_BASE, CSR_OP_SET, 32'h4);
        csr_read(HPM_CNT_LO_BASE, d, h);
        n_tests++; if (d !== 32'h1234) begin n_fail++;
            $display("FAIL hi_write_keeps_lo: got %h, want 1234", d); end
        csr_read(HPM_CNT_HI_BASE, d, h);
        n_tests++; if (d !== 32'h5) begin n_fail++;
            $display("FAIL hi_set_op: got %h, want 5", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, want; logic h;
        csr_write(HPM_OVF_EN, CSR_OP_WRITE, 32'h1);
        for (int s = 0; s < 2; s++) begin
            want = (s == 1) ? 32'hFFFF_FFFF : 32'h0;
            if (s == 1) csr_write(HPM_MODE, CSR_OP_SET, 32'h2);
            csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'hFFFF_FFFF);
            csr_write(HPM_CNT_HI_BASE, CSR_OP_WRITE, 32'hFFFF_FFFF);
            pulse(16'h0004);
            csr_read(HPM_OVF, d, h);
            n_tests++; if (d !== 32'h0 || last_irq !== 1'b0) begin n_fail++;
                $display("FAIL ovf_early_s%0d: ovf %h irq %b, want 0 0", s, d, last_irq); end
            csr_read(HPM_OVF, d, h);
            n_tests++; if (d !== 32'h1 || last_irq !== 1'b0) begin n_fail++;
                $display("FAIL ovf_set_s%0d: ovf %h irq %b, want 1 0", s, d, last_irq); end
            csr_read(HPM_CNT_LO_BASE, d, h);
            n_tests++; if (d !== want || last_irq !== 1'b1) begin n_fail++;
                $display("FAIL ovf_lo_s%0d: lo %h irq %b, want %h 1", s, d, last_irq, want); end
            csr_read(HPM_CNT_HI_BASE, d, h);
            n_tests++; if (d !== want) begin n_fail++;
                $display("FAIL ovf_hi_s%0d: got %h, want %h", s, d, want); end
            csr_write(HPM_OVF, CSR_OP_CLEAR, 32'h1);
            csr_read(HPM_OVF, d, h);
            n_tests++; if (d !== 32'h0 || last_irq !== 1'b1) begin n_fail++;
                $display("FAIL ovf_clear_s%0d: ovf %h irq %b, want 0 1", s, d, last_irq); end
            csr_read(HPM_OVF, d, h);
            n_tests++; if (last_irq !== 1'b0) begin n_fail++;
                $display("FAIL irq_drop_s%0d: got %b, want 0", s, last_irq); end
        end
        csr_write(HPM_MODE, CSR_OP_CLEAR, 32'h2);
        // Overflow set and software clear in the same cycle: the set wins.
        csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'hFFFF_FFFF);
        csr_write(HPM_CNT_HI_BASE, CSR_OP_WRITE, 32'hFFFF_FFFF);
        pulse(16'h0004);
        csr_write(HPM_OVF, CSR_OP_CLEAR, 32'h1);
        csr_read(HPM_OVF, d, h);
        n_tests++; if (d !== 32'h1) begin n_fail++;
            $display("FAIL ovf_set_beats_clear: got %h, want 1", d); end
        csr_write(HPM_OVF, CSR_OP_CLEAR, 32'h1);
        csr_write(HPM_OVF_EN, CSR_OP_WRITE, 32'h0);
        idle(2);
    endtask

    task automatic test_write_wins();
        logic [31:0] d; logic h;
        csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'h0);
        csr_write(HPM_CNT_HI_BASE, CSR_OP_WRITE, 32'h0);
        pulse(16'h0004);
        csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'h10);   // inc_q[0] set this cycle
        csr_read(HPM_CNT_LO_BASE, d, h);
        n_tests++; if (d !== 32'h10) begin n_fail++;
            $display("FAIL lo_write_wins: got %h, want 10", d); end
        pulse(16'h0004);
        csr_write(HPM_CNT_HI_BASE, CSR_OP_WRITE, 32'h7);
        csr_read(HPM_CNT_HI_BASE, d, h);
        n_tests++; if (d !== 32'h7) begin n_fail++;
            $display("FAIL hi_write_wins_hi: got %h, want 7", d); end
        csr_read(HPM_CNT_LO_BASE, d, h);
        n_tests++; if (d !== 32'h10) begin n_fail++;
            $display("FAIL hi_write_wins_lo: got %h, want 10", d); end
    endtask

    task automatic test_inhibit_mode();
        logic [31:0] d; logic h;
        csr_write(HPM_EVT_BASE + 12'd1, CSR_OP_WRITE, 32'd5);
        csr_write(HPM_CNT_LO_BASE + 12'd1, CSR_OP_WRITE, 32'h0);
        events = 16'h0010;
        idle(3);                                          // three counted events
        csr_write(HPM_INHIBIT, CSR_OP_WRITE, 32'h2);      // this cycle's event still counts
        idle(3);
        events = '0;
        csr_read(HPM_CNT_LO_BASE + 12'd1, d, h);
        n_tests++; if (d !== 32'd4) begin n_fail++;
            $display("FAIL inhibit_freeze: got %h, want 4", d); end
        csr_read(HPM_CNT_LO_BASE + 12'd1, d, h);
        n_tests++; if (d !== 32'd4) begin n_fail++;
            $display("FAIL inhibit_stays: got %h, want 4", d); end
        csr_write(HPM_INHIBIT, CSR_OP_CLEAR, 32'h2);
        csr_write(HPM_MODE, CSR_OP_SET, 32'h2);
        csr_read(HPM_MODE, d, h);
        n_tests++; if (d !== 32'h3) begin n_fail++;
            $display("FAIL mode_set: got %h, want 3", d); end
        csr_write(HPM_MODE, CSR_OP_CLEAR, 32'h2);
        csr_read(HPM_MODE, d, h);
        n_tests++; if (d !== 32'h1) begin n_fail++;
            $display("FAIL mode_clear_sat: got %h, want 1", d); end
        csr_write(HPM_MODE, CSR_OP_CLEAR, 32'h1);
        pulse(16'h0010);
        idle(1);
        csr_read(HPM_CNT_LO_BASE + 12'd1, d, h);
        n_tests++; if (d !== 32'd4) begin n_fail++;
            $display("FAIL mode_disabled: got %h, want 4", d); end
        csr_write(HPM_MODE, CSR_OP_WRITE, 32'h1);
    endtask

    task automatic test_widths();
        logic [31:0] d; logic h;
        csr_write(HPM_EVT_BASE + 12'd2, CSR_OP_WRITE, 32'hFFFF_FFFF);
        csr_read(HPM_EVT_BASE + 12'd2, d, h);
        n_tests++; if (d !== 32'h1F) begin n_fail++;
            $display("FAIL sel_width: got %h, want 1f", d); end
        csr_write(HPM_INHIBIT, CSR_OP_WRITE, 32'hFFFF_FFFF);
        csr_read(HPM_INHIBIT, d, h);
        n_tests++; if (d !== 32'hF) begin n_fail++;
            $display("FAIL inhibit_width: got %h, want f", d); end
        csr_write(HPM_INHIBIT, CSR_OP_WRITE, 32'h0);
        csr_write(HPM_CNT_LO_BASE + 12'd2, CSR_OP_WRITE, 32'h0);
        pulse('1);                                        // select 31 is out of range
        idle(1);
        csr_read(HPM_CNT_LO_BASE + 12'd2, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL sel_out_of_range: got %h, want 0", d); end
        csr_write(HPM_EVT_BASE + 12'd2, CSR_OP_WRITE, 32'(N_EVENTS));
        pulse(16'h8000);
        idle(1);
        csr_read(HPM_CNT_LO_BASE + 12'd2, d, h);
        n_tests++; if (d !== 32'h1) begin n_fail++;
            $display("FAIL sel_last_event: got %h, want 1", d); end
    endtask

    task automatic test_random();
        logic [31:0]         d; logic h;
        int unsigned         sel [N_CNT];
        logic [63:0]         expc [N_CNT];
        logic [N_CNT-1:0]    inh;
        logic                en;
        logic [N_EVENTS-1:0] ev;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(N_CNT); i++) begin
                sel[i]  = $urandom_range(0, N_EVENTS + 2);
                expc[i] = '0;
                csr_write(HPM_EVT_BASE + 12'(i), CSR_OP_WRITE, 32'(sel[i]));
                csr_write(HPM_CNT_LO_BASE + 12'(i), CSR_OP_WRITE, 32'h0);
                csr_write(HPM_CNT_HI_BASE + 12'(i), CSR_OP_WRITE, 32'h0);
            end
            inh = N_CNT'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            csr_write(HPM_INHIBIT, CSR_OP_WRITE, 32'(inh));
            csr_write(HPM_MODE, CSR_OP_WRITE, {31'b0, en});
            for (int c = 0; c < 50; c++) begin
                ev = N_EVENTS'($urandom);
                for (int i = 0; i < int'(N_CNT); i++) begin
                    if (en && !inh[i] && sel[i] >= 1 && sel[i] <= N_EVENTS && ev[sel[i] - 1])
                        expc[i] = expc[i] + 1;
                end
                events = ev;
                @(posedge clk); #1;
            end
            events = '0;
            idle(1);
            for (int i = 0; i < int'(N_CNT); i++) begin
                csr_read(HPM_CNT_LO_BASE + 12'(i), d, h);
                n_tests++; if (d !== expc[i][31:0]) begin n_fail++;
                    $display("FAIL random_r%0d_lo%0d: got %h, want %h", r, i, d, expc[i][31:0]);
                end
                csr_read(HPM_CNT_HI_BASE + 12'(i), d, h);
                n_tests++; if (d !== expc[i][63:32]) begin n_fail++;
                    $display("FAIL random_r%0d_hi%0d: got %h, want %h", r, i, d, expc[i][63:32]);
                end
            end
        end
        csr_write(HPM_INHIBIT, CSR_OP_WRITE, 32'h0);
        csr_write(HPM_MODE, CSR_OP_WRITE, 32'h1);
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic h;
        csr_write(HPM_EVT_BASE, CSR_OP_WRITE, 32'd1);
        csr_write(HPM_CNT_LO_BASE, CSR_OP_WRITE, 32'h55);
        pulse(16'h0001);
        #2 rst_n = 1'b0;                                  // increment still in flight
        @(posedge clk); #1;
        rst_n = 1'b1;
        csr_read(HPM_CNT_LO_BASE, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL areset_lo: got %h, want 0", d); end
        csr_read(HPM_EVT_BASE, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++;
            $display("FAIL areset_sel: got %h, want 0", d); end
        csr_read(HPM_MODE, d, h);
        n_tests++; if (d !== 32'h1) begin n_fail++;
            $display("FAIL areset_mode: got %h, want 1", d); end
        csr_read(HPM_CNT_LO_BASE, d, h);
        n_tests++; if (d !== 32'h0 || last_irq !== 1'b0) begin n_fail++;
            $display("FAIL areset_dropped: lo %h irq %b, want 0 0", d, last_irq); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_count();
        test_carry();
        test_overflow();
        test_write_wins();
        test_inhibit_mode();
        test_widths();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
